// File: rtl/pc_ras_unit.sv
// ============================================================================
// Module   : pc_ras_unit
// Purpose  : Program counter with next-PC select, stall hold and return-address stack
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ras_unit #(
  parameter int                N_BITS       = 32,
  parameter logic [N_BITS-1:0] RESET_VECTOR = 32'h0040_0000,
  parameter int                PC_INC       = 4,
  parameter int                RAS_DEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall_i,
  input  logic [1:0]        sel_i,
  input  logic [N_BITS-1:0] target_i,
  input  logic              link_i,
  output logic [N_BITS-1:0] pc_value_o,
  output logic [N_BITS-1:0] pc_next_seq_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              ras_overflow_o,
  output logic              ras_underflow_o
);

  localparam int         c_PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int         c_CNT_W   = $clog2(RAS_DEPTH + 1);
  localparam logic [1:0] c_SEL_SEQ = 2'b00;
  localparam logic [1:0] c_SEL_BR  = 2'b01;
  localparam logic [1:0] c_SEL_JMP = 2'b10;
  localparam logic [1:0] c_SEL_RET = 2'b11;

  logic [N_BITS-1:0]  r_pc;
  logic [N_BITS-1:0]  r_ras [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic               r_ovf;
  logic               r_unf;

  logic [N_BITS-1:0]  w_seq;
  logic [c_PTR_W-1:0] w_ptr_inc;
  logic [c_PTR_W-1:0] w_ptr_dec;
  logic               w_empty;
  logic               w_full;

  always_comb begin
    w_seq     = r_pc + N_BITS'(PC_INC);
    w_ptr_inc = (r_ptr == c_PTR_W'(RAS_DEPTH - 1)) ? '0 : r_ptr + c_PTR_W'(1);
    w_ptr_dec = (r_ptr == '0) ? c_PTR_W'(RAS_DEPTH - 1) : r_ptr - c_PTR_W'(1);
    w_empty   = (r_count == '0);
    w_full    = (r_count == c_CNT_W'(RAS_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc    <= RESET_VECTOR;
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!stall_i) begin
      case (sel_i)
        c_SEL_SEQ: r_pc <= w_seq;
        c_SEL_BR, c_SEL_JMP: begin
          r_pc <= target_i;
          if (link_i) begin
            // When full, ptr+1 is the oldest slot, so the push overwrites it.
            r_ras[w_ptr_inc] <= w_seq;
            r_ptr            <= w_ptr_inc;
            if (w_full) r_ovf   <= 1'b1;
            else        r_count <= r_count + c_CNT_W'(1);
          end
        end
        c_SEL_RET: begin
          if (!w_empty) begin
            r_pc <= r_ras[r_ptr];
            if (link_i) begin
              r_ras[r_ptr] <= w_seq;
            end else begin
              r_ptr   <= w_ptr_dec;
              r_count <= r_count - c_CNT_W'(1);
            end
          end else begin
            r_pc  <= target_i;
            r_unf <= 1'b1;
            if (link_i) begin
              r_ras[w_ptr_inc] <= w_seq;
              r_ptr            <= w_ptr_inc;
              r_count          <= c_CNT_W'(1);
            end
          end
        end
        default: r_pc <= w_seq;
      endcase
    end
  end

  assign pc_value_o      = r_pc;
  assign pc_next_seq_o   = w_seq;
  assign ras_empty_o     = w_empty;
  assign ras_full_o      = w_full;
  assign ras_overflow_o  = r_ovf;
  assign ras_underflow_o = r_unf;

endmodule

`default_nettype wire
